// File: rtl/exmem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : exmem_pkg
// Purpose : Shared definitions for the MiniMIPS external memory / MMIO block:
//           region-decode enum, address-map offset helpers and clog2.
// Ports   : (package, no ports)
// Revision: 1.0 - initial release
// ============================================================================
package exmem_pkg;

  // Which part of the address space a given word address falls into.
  typedef enum logic [1:0] {
    REG_RAM  = 2'd0,
    REG_SW   = 2'd1,
    REG_LED  = 2'd2,
    REG_STAT = 2'd3
  } region_e;

  // Offsets of each MMIO group relative to the bottom of the I/O window.
  localparam int SW_OFS = 0;

  function automatic int led_ofs(input int num_sw);
    return num_sw;
  endfunction

  function automatic int stat_ofs(input int num_sw, input int num_led);
    return num_sw + num_led;
  endfunction

  // First address of the I/O window; the status register lands on the
  // very top address of the space.
  function automatic int io_base(input int addr_w, input int num_sw,
                                 input int num_led);
    return (1 << addr_w) - num_sw - num_led - 1;
  endfunction

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/exmem_mmio_if.sv
`default_nettype none
// ============================================================================
// Module  : exmem_mmio_if
// Purpose : Core memory-port bundle (data/addr/wen/q) between the MiniMIPS
//           core (master) and the external memory / MMIO block (slave).
// Signals : data - write data        addr - word address
//           wen  - write enable      q    - registered read data
// Revision: 1.0 - initial release
// ============================================================================
interface exmem_mmio_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) ();

  logic [DATA_W-1:0] data;
  logic [ADDR_W-1:0] addr;
  logic              wen;
  logic [DATA_W-1:0] q;

  modport master (output data, output addr, output wen, input  q);
  modport slave  (input  data, input  addr, input  wen, output q);

endinterface
`default_nettype wire

// File: rtl/exmem_mmio_switch_debounce.sv
`default_nettype none
// ============================================================================
// Module  : switch_debounce
// Purpose : One DATA_W-wide switch channel: 2-flop synchroniser followed by a
//           stability counter. The debounced value only follows the synced
//           value after a mismatch has held constant for DEBOUNCE_CYC cycles.
// Ports   : clk, reset  - clock, async active-high reset
//           raw_i       - raw switch bits (asynchronous to clk)
//           deb_o       - debounced value
//           chg_o       - high in the cycle whose closing edge updates deb_o
// Revision: 1.0 - initial release
// ============================================================================
module switch_debounce
  import exmem_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] raw_i,
  output logic [DATA_W-1:0] deb_o,
  output logic              chg_o
);

  localparam int               CNT_W    = clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYC);
  // cnt counts the stable cycles after the one in which the mismatch first
  // appeared, so the last qualifying cycle is reached at DEBOUNCE_CYC-1.
  localparam logic [CNT_W-1:0] FIRE_RUN = CNT_W'(DEBOUNCE_CYC - 1);

  logic [DATA_W-1:0] meta_q, sync_q, prev_q, deb_q, deb_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, run;
  logic              mismatch, stable, fire;

  always_comb begin
    mismatch = (sync_q != deb_q);
    stable   = (sync_q == prev_q);
    run      = '0;
    if (stable) begin
      run = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    end
    fire  = mismatch && (run == FIRE_RUN);
    cnt_d = (!mismatch || fire) ? '0 : run;
    deb_d = fire ? sync_q : deb_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
      deb_q  <= '0;
      cnt_q  <= '0;
    end else begin
      meta_q <= raw_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      deb_q  <= deb_d;
      cnt_q  <= cnt_d;
    end
  end

  assign deb_o = deb_q;
  assign chg_o = fire;

endmodule
`default_nettype wire

// File: rtl/exmem_mmio.sv
`default_nettype none
// ============================================================================
// Module  : exmem_mmio
// Purpose : External memory for the MiniMIPS core: synchronous read-first RAM
//           below IO_BASE, and an MMIO window at the top of the address space
//           holding debounced switch channels, LED registers and a sticky
//           switch-change status register (cleared by reading it).
// Ports   : clk, reset - clock, async active-high reset
//           bus        - core memory port (data/addr/wen in, q out)
//           switches   - raw switch inputs, NUM_SW channels of DATA_W bits
//           leds       - LED registers, NUM_LED channels of DATA_W bits
// Revision: 1.0 - initial release
// ============================================================================
module exmem_mmio
  import exmem_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 8,
  parameter int NUM_SW       = 1,
  parameter int NUM_LED      = 1,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  exmem_mmio_if.slave               bus,
  input  logic [NUM_SW*DATA_W-1:0]  switches,
  output logic [NUM_LED*DATA_W-1:0] leds
);

  localparam int IO_BASE = io_base(ADDR_W, NUM_SW, NUM_LED);
  localparam logic [ADDR_W-1:0] SW_BASE   = ADDR_W'(IO_BASE + SW_OFS);
  localparam logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'(IO_BASE + stat_ofs(NUM_SW, NUM_LED));

  logic [DATA_W-1:0]         mem [IO_BASE];
  logic [NUM_SW*DATA_W-1:0]  deb_flat;
  logic [NUM_SW-1:0]         chg;
  logic [NUM_SW-1:0]         status_q, status_d;
  logic [NUM_LED*DATA_W-1:0] leds_q;
  logic [DATA_W-1:0]         q_q, q_d;
  logic [ADDR_W-1:0]         ofs;
  region_e                   region;

  // --------------------------------------------------------------------------
  // Switch channels
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    switch_debounce #(
      .DATA_W       (DATA_W),
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_deb (
      .clk   (clk),
      .reset (reset),
      .raw_i (switches[i*DATA_W +: DATA_W]),
      .deb_o (deb_flat[i*DATA_W +: DATA_W]),
      .chg_o (chg[i])
    );
  end

  // --------------------------------------------------------------------------
  // Address decode: ofs is the offset inside the I/O window (switches first,
  // then LEDs, then the status word at the top).
  // --------------------------------------------------------------------------
  always_comb begin
    ofs = bus.addr - SW_BASE;
    if (bus.addr < SW_BASE) begin
      region = REG_RAM;
    end else if (bus.addr == STAT_ADDR) begin
      region = REG_STAT;
    end else if (ofs < ADDR_W'(led_ofs(NUM_SW))) begin
      region = REG_SW;
    end else begin
      region = REG_LED;
    end
  end

  // --------------------------------------------------------------------------
  // Read mux; every source is the pre-edge value, which gives read-first RAM
  // and pre-write LED / pre-clear status readback for free.
  // --------------------------------------------------------------------------
  always_comb begin
    q_d = '0;
    case (region)
      REG_RAM: q_d = mem[bus.addr];
      REG_SW: begin
        for (int i = 0; i < NUM_SW; i++) begin
          if (ofs == ADDR_W'(SW_OFS + i)) q_d = deb_flat[i*DATA_W +: DATA_W];
        end
      end
      REG_LED: begin
        for (int j = 0; j < NUM_LED; j++) begin
          if (ofs == ADDR_W'(led_ofs(NUM_SW) + j)) q_d = leds_q[j*DATA_W +: DATA_W];
        end
      end
      default: q_d = DATA_W'(status_q);
    endcase
  end

  // A change landing on the same edge as a status read must survive the
  // clear, so the set term is OR-ed in after the clear.
  always_comb begin
    status_d = ((region == REG_STAT) ? '0 : status_q) | chg;
  end

  // RAM contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (bus.wen && (region == REG_RAM)) begin
      mem[bus.addr] <= bus.data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q      <= '0;
      status_q <= '0;
      leds_q   <= '0;
    end else begin
      q_q      <= q_d;
      status_q <= status_d;
      for (int j = 0; j < NUM_LED; j++) begin
        if (bus.wen && (region == REG_LED) && (ofs == ADDR_W'(led_ofs(NUM_SW) + j))) begin
          leds_q[j*DATA_W +: DATA_W] <= bus.data;
        end
      end
    end
  end

  assign bus.q = q_q;
  assign leds  = leds_q;

endmodule
`default_nettype wire

// File: tb/tb_exmem_mmio.sv
`default_nettype none
// ============================================================================
// Module  : tb_exmem_mmio
// Purpose : Directed self-checking bench for exmem_mmio. dut1 uses the default
//           parameters (IO_BASE=253: SW0=253, LED0=254, STAT=255); dut2 uses
//           DATA_W=16, ADDR_W=10, NUM_SW=2, NUM_LED=3 (IO_BASE=1018:
//           SW0/1=1018/1019, LED0..2=1020..1022, STAT=1023).
// Revision: 1.0 - initial release
// ============================================================================
module tb_exmem_mmio;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  sw1;
  logic [7:0]  leds1;
  logic [31:0] sw2;
  logic [47:0] leds2;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  exmem_mmio_if #(.DATA_W(8),  .ADDR_W(8))  bus1 ();
  exmem_mmio_if #(.DATA_W(16), .ADDR_W(10)) bus2 ();

  exmem_mmio #(
    .DATA_W(8), .ADDR_W(8), .NUM_SW(1), .NUM_LED(1), .DEBOUNCE_CYC(4)
  ) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .switches(sw1), .leds(leds1)
  );

  exmem_mmio #(
    .DATA_W(16), .ADDR_W(10), .NUM_SW(2), .NUM_LED(3), .DEBOUNCE_CYC(4)
  ) dut2 (
    .clk(clk), .reset(reset), .bus(bus2), .switches(sw2), .leds(leds2)
  );

  // Advance n rising edges, leaving time 1 ns past the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    sw1 = '0; sw2 = '0;
    bus1.wen = 1'b0; bus1.addr = '0; bus1.data = '0;
    bus2.wen = 1'b0; bus2.addr = '0; bus2.data = '0;
    #3 reset = 1'b1;
    #1;
    n_cmp++; if (bus1.q !== 8'h00) begin n_bad++; $display("FAIL rst_q1: got %h want 00", bus1.q); end
    n_cmp++; if (leds1 !== 8'h00) begin n_bad++; $display("FAIL rst_leds1: got %h want 00", leds1); end
    n_cmp++; if (leds2 !== 48'h0) begin n_bad++; $display("FAIL rst_leds2: got %h want 0", leds2); end
    #8 reset = 1'b0;
    bus1.addr = 8'd253;
    step(1);
    n_cmp++; if (bus1.q !== 8'h00) begin n_bad++; $display("FAIL rst_sw_rd: got %h want 00", bus1.q); end
  endtask

  task automatic test_ram();
    bus1.wen = 1'b1; bus1.addr = 8'h10; bus1.data = 8'h14; step(1);
    bus1.addr = 8'h11; bus1.data = 8'hA5; step(1);
    bus1.wen = 1'b0; bus1.addr = 8'h10; step(1);
    n_cmp++; if (bus1.q !== 8'h14) begin n_bad++; $display("FAIL ram_rd10: got %h want 14", bus1.q); end
    bus1.addr = 8'h11; step(1);
    n_cmp++; if (bus1.q !== 8'hA5) begin n_bad++; $display("FAIL ram_rd11: got %h want A5", bus1.q); end
    // Write while reading the same word: old data now, new data next cycle.
    bus1.wen = 1'b1; bus1.addr = 8'h10; bus1.data = 8'h3C; step(1);
    n_cmp++; if (bus1.q !== 8'h14) begin n_bad++; $display("FAIL ram_rdfirst: got %h want 14", bus1.q); end
    bus1.wen = 1'b0; step(1);
    n_cmp++; if (bus1.q !== 8'h3C) begin n_bad++; $display("FAIL ram_newdata: got %h want 3C", bus1.q); end
  endtask

  task automatic test_led();
    bus1.wen = 1'b1; bus1.addr = 8'd254; bus1.data = 8'h5A; step(1);
    n_cmp++; if (leds1 !== 8'h5A) begin n_bad++; $display("FAIL led_wr: got %h want 5A", leds1); end
    n_cmp++; if (bus1.q !== 8'h00) begin n_bad++; $display("FAIL led_prewrite_rd: got %h want 00", bus1.q); end
    bus1.wen = 1'b0; step(1);
    n_cmp++; if (bus1.q !== 8'h5A) begin n_bad++; $display("FAIL led_rd: got %h want 5A", bus1.q); end
    bus1.wen = 1'b1; bus1.addr = 8'd253; bus1.data = 8'hEE; step(1);
    bus1.wen = 1'b0; step(1);
    n_cmp++; if (bus1.q !== 8'h00) begin n_bad++; $display("FAIL sw_wr_ignored: got %h want 00", bus1.q); end
    n_cmp++; if (leds1 !== 8'h5A) begin n_bad++; $display("FAIL sw_wr_leds: got %h want 5A", leds1); end
    bus1.addr = 8'h10; step(1);
    n_cmp++; if (bus1.q !== 8'h3C) begin n_bad++; $display("FAIL sw_wr_ram: got %h want 3C", bus1.q); end
  endtask

  task automatic test_debounce();
    logic [7:0] exp;
    // Raw change applied just after an edge: synchroniser at +1/+2, four
    // stable mismatch cycles, debounced at +6, visible on q at +7.
    bus1.addr = 8'd253;
    sw1 = 8'h81;
    for (int k = 1; k <= 7; k++) begin
      step(1);
      exp = (k >= 7) ? 8'h81 : 8'h00;
      n_cmp++; if (bus1.q !== exp) begin n_bad++; $display("FAIL deb_edge%0d: got %h want %h", k, bus1.q, exp); end
    end
    // Three-cycle glitch must be rejected.
    sw1 = 8'hFF; step(3);
    sw1 = 8'h81;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      n_cmp++; if (bus1.q !== 8'h81) begin n_bad++; $display("FAIL glitch_cyc%0d: got %h want 81", k, bus1.q); end
    end
  endtask

  task automatic test_status();
    bus1.addr = 8'd255; step(1);
    n_cmp++; if (bus1.q !== 8'h01) begin n_bad++; $display("FAIL stat_rd: got %h want 01", bus1.q); end
    step(1);
    n_cmp++; if (bus1.q !== 8'h00) begin n_bad++; $display("FAIL stat_clr: got %h want 00", bus1.q); end
    // A rejected glitch must not set status.
    bus1.addr = 8'h10;
    sw1 = 8'hFF; step(3);
    sw1 = 8'h81; step(8);
    bus1.addr = 8'd255; step(1);
    n_cmp++; if (bus1.q !== 8'h00) begin n_bad++; $display("FAIL stat_glitch: got %h want 00", bus1.q); end
    // Debounced change lands on the same edge as the status read.
    bus1.addr = 8'h10;
    sw1 = 8'h00; step(5);
    bus1.addr = 8'd255; step(1);
    n_cmp++; if (bus1.q !== 8'h00) begin n_bad++; $display("FAIL stat_race_pre: got %h want 00", bus1.q); end
    step(1);
    n_cmp++; if (bus1.q !== 8'h01) begin n_bad++; $display("FAIL stat_set_wins: got %h want 01", bus1.q); end
    step(1);
    n_cmp++; if (bus1.q !== 8'h00) begin n_bad++; $display("FAIL stat_race_clr: got %h want 00", bus1.q); end
  endtask

  task automatic test_reset_mid();
    // Debounce 0x81 in (sets status), then start a change back and reset
    // partway through it.
    bus1.addr = 8'h10;
    sw1 = 8'h81; step(10);
    sw1 = 8'h00; step(3);
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (leds1 !== 8'h00) begin n_bad++; $display("FAIL rmid_leds: got %h want 00", leds1); end
    n_cmp++; if (bus1.q !== 8'h00) begin n_bad++; $display("FAIL rmid_q: got %h want 00", bus1.q); end
    #2 reset = 1'b0;
    step(1);
    n_cmp++; if (bus1.q !== 8'h3C) begin n_bad++; $display("FAIL rmid_ram: got %h want 3C", bus1.q); end
    bus1.addr = 8'd255; step(1);
    n_cmp++; if (bus1.q !== 8'h00) begin n_bad++; $display("FAIL rmid_stat: got %h want 00", bus1.q); end
    bus1.addr = 8'd253; step(1);
    n_cmp++; if (bus1.q !== 8'h00) begin n_bad++; $display("FAIL rmid_deb: got %h want 00", bus1.q); end
    bus1.addr = 8'd254; step(1);
    n_cmp++; if (bus1.q !== 8'h00) begin n_bad++; $display("FAIL rmid_led_rd: got %h want 00", bus1.q); end
  endtask

  task automatic test_sweep();
    bus2.wen = 1'b1; bus2.addr = 10'd1017; bus2.data = 16'hBEEF; step(1);
    bus2.addr = 10'd1022; bus2.data = 16'h1234; step(1);
    n_cmp++; if (leds2 !== 48'h1234_0000_0000) begin n_bad++; $display("FAIL sw_led2: got %h want 123400000000", leds2); end
    bus2.wen = 1'b0; bus2.addr = 10'd1017; step(1);
    n_cmp++; if (bus2.q !== 16'hBEEF) begin n_bad++; $display("FAIL sw_ram1017: got %h want BEEF", bus2.q); end
    bus2.addr = 10'd1022; step(1);
    n_cmp++; if (bus2.q !== 16'h1234) begin n_bad++; $display("FAIL sw_led2_rd: got %h want 1234", bus2.q); end
    bus2.addr = 10'd1020; step(1);
    n_cmp++; if (bus2.q !== 16'h0000) begin n_bad++; $display("FAIL sw_led0_rd: got %h want 0000", bus2.q); end
    sw2 = 32'h0000_00AA;
    bus2.addr = 10'd1017; step(10);
    bus2.addr = 10'd1018; step(1);
    n_cmp++; if (bus2.q !== 16'h00AA) begin n_bad++; $display("FAIL sw_ch0_a: got %h want 00AA", bus2.q); end
    bus2.addr = 10'd1019; step(1);
    n_cmp++; if (bus2.q !== 16'h0000) begin n_bad++; $display("FAIL sw_ch1_a: got %h want 0000", bus2.q); end
    bus2.addr = 10'd1023; step(1);
    n_cmp++; if (bus2.q !== 16'h0001) begin n_bad++; $display("FAIL sw_stat_a: got %h want 0001", bus2.q); end
    sw2 = 32'h5500_00AA;
    bus2.addr = 10'd1017; step(10);
    bus2.addr = 10'd1019; step(1);
    n_cmp++; if (bus2.q !== 16'h5500) begin n_bad++; $display("FAIL sw_ch1_b: got %h want 5500", bus2.q); end
    bus2.addr = 10'd1018; step(1);
    n_cmp++; if (bus2.q !== 16'h00AA) begin n_bad++; $display("FAIL sw_ch0_b: got %h want 00AA", bus2.q); end
    bus2.addr = 10'd1023; step(1);
    n_cmp++; if (bus2.q !== 16'h0002) begin n_bad++; $display("FAIL sw_stat_b: got %h want 0002", bus2.q); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_led();
    test_debounce();
    test_status();
    test_reset_mid();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
